// File: rtl/vector_reg_file_masked.sv
// ============================================================================
// vector_reg_file_masked : SIMD vector register file with lane masking,
// broadcast writes, write-to-read bypass, pending-write scoreboard, bulk clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vector_reg_file_masked #(
  parameter int regSize     = 8,
  parameter int regQuantity = 8,
  parameter int selBits     = 3,
  parameter int vecSize     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              regWrEn,
  input  logic [selBits-1:0]                regToWrite,
  input  logic [vecSize-1:0][regSize-1:0]   regWriteData,
  input  logic [vecSize-1:0]                laneMask,
  input  logic                              bcastEn,
  input  logic [selBits-1:0]                rSel1,
  input  logic [selBits-1:0]                rSel2,
  output logic [vecSize-1:0][regSize-1:0]   reg1Out,
  output logic [vecSize-1:0][regSize-1:0]   reg2Out,
  input  logic                              resvEn,
  input  logic [selBits-1:0]                resvReg,
  output logic                              hazard1,
  output logic                              hazard2,
  output logic [regQuantity-1:0]            busyMask,
  input  logic                              clrStart,
  output logic                              clrBusy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [selBits-1:0] c_last_reg = selBits'(regQuantity - 1);

  state_t                            state, state_nxt;
  logic [selBits-1:0]                clr_cnt, clr_cnt_nxt;
  logic [vecSize-1:0][regSize-1:0]   regs [regQuantity];
  logic [vecSize-1:0][regSize-1:0]   lane_val;
  logic [vecSize-1:0][regSize-1:0]   rd1, rd2;
  logic                              idle;
  logic                              wr_act;
  logic                              wr_commit;
  logic                              wr_ok, sel1_ok, sel2_ok, resv_ok;
  logic                              busy1, busy2;

  function automatic logic in_range(input logic [selBits-1:0] s);
    return int'(s) < regQuantity;
  endfunction

  assign idle      = (state == IDLE);
  assign wr_ok     = in_range(regToWrite);
  assign sel1_ok   = in_range(rSel1);
  assign sel2_ok   = in_range(rSel2);
  assign resv_ok   = in_range(resvReg);
  assign wr_act    = idle && regWrEn;
  // A clear request takes priority over a write presented in the same cycle.
  assign wr_commit = wr_act && !clrStart && wr_ok;
  assign clrBusy   = (state == CLEAR);

  always_comb begin
    for (int i = 0; i < vecSize; i++) begin
      lane_val[i] = bcastEn ? regWriteData[0] : regWriteData[i];
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (sel1_ok) rd1 = regs[rSel1];
    if (sel2_ok) rd2 = regs[rSel2];
    for (int i = 0; i < vecSize; i++) begin
      if (wr_act && wr_ok && regToWrite == rSel1 && laneMask[i]) rd1[i] = lane_val[i];
      if (wr_act && wr_ok && regToWrite == rSel2 && laneMask[i]) rd2[i] = lane_val[i];
    end
    reg1Out = rst ? rd1 : '0;
    reg2Out = rst ? rd2 : '0;
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (sel1_ok) busy1 = busyMask[rSel1];
    if (sel2_ok) busy2 = busyMask[rSel2];
    hazard1 = busy1 && !(wr_act && regToWrite == rSel1);
    hazard2 = busy2 && !(wr_act && regToWrite == rSel2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      IDLE: begin
        if (clrStart) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == c_last_reg) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < regQuantity; r++) regs[r] <= '0;
      busyMask <= '0;
    end else if (state == CLEAR) begin
      regs[clr_cnt]     <= '0;
      busyMask[clr_cnt] <= 1'b0;
    end else begin
      if (wr_commit) begin
        for (int i = 0; i < vecSize; i++) begin
          if (laneMask[i]) regs[regToWrite][i] <= lane_val[i];
        end
      end
      // Reservation is applied after the writeback release so a same-edge set wins.
      if (regWrEn && wr_ok) busyMask[regToWrite] <= 1'b0;
      if (resvEn && resv_ok) busyMask[resvReg] <= 1'b1;
    end
  end

endmodule

`default_nettype wire
